// File: rtl/pe_conv_sched_pkg.sv
// pe_sched_pkg: shared types and constants for the 25-tap PE conv scheduler.
//   state_t - scheduler FSM states
//   tag_t   - per-issue tag carried alongside the PE pipeline
//   K, PE_LAT, MIN_GAP - kernel size, PE latency, minimum issue spacing
//                        between a psum write and its read-back
package pe_sched_pkg;
    localparam int K       = 5;
    localparam int PE_LAT  = 2;
    localparam int MIN_GAP = 3;

    typedef enum logic [2:0] {IDLE, ISSUE, GAP, DRAIN, DONE} state_t;

    typedef struct packed {
        logic       valid;
        logic [4:0] row;
        logic [4:0] col;
        logic       last;   // final channel: result is final, not partial
        logic       nz_ch;  // channel != 0: psum must come from the buffer
    } tag_t;

    // Output positions per channel, from (output size - 1).
    function automatic logic [9:0] pos_cnt(input logic [4:0] o_m1);
        logic [9:0] o;
        o = {5'd0, o_m1} + 10'd1;
        return o * o;
    endfunction
endpackage

// File: rtl/pe_conv_sched_if.sv
// pe_conv_sched_if: scheduler <-> window buffer / PE / output buffer bus.
//   win_*   - window request (valid/ready handshake) and origin/channel
//   msb_ctrl, psum_sel, relu_en, quan_en - PE controls
//   wr_*    - output buffer write strobe, address and final flag
// master = scheduler, slave = buffers/PE side.
interface pe_conv_sched_if;
    logic       win_valid;
    logic       win_ready;
    logic [4:0] win_row;
    logic [4:0] win_col;
    logic [3:0] win_ch;
    logic       msb_ctrl;
    logic       psum_sel;
    logic       relu_en;
    logic       quan_en;
    logic       wr_valid;
    logic [4:0] wr_row;
    logic [4:0] wr_col;
    logic       wr_last;

    modport master (
        output win_valid, win_row, win_col, win_ch,
        output msb_ctrl, psum_sel, relu_en, quan_en,
        output wr_valid, wr_row, wr_col, wr_last,
        input  win_ready
    );
    modport slave (
        input  win_valid, win_row, win_col, win_ch,
        input  msb_ctrl, psum_sel, relu_en, quan_en,
        input  wr_valid, wr_row, wr_col, wr_last,
        output win_ready
    );
endinterface

// File: rtl/pe_conv_sched_tag_pipe.sv
// pe_tag_pipe: DEPTH-deep shift register of issue tags, synchronous clear.
//   clk, rst - clock, synchronous active-high clear
//   tag_in   - tag of this cycle's handshake (all-zero for a bubble)
//   tag_s1   - tag one cycle after issue (PE sum stage)
//   tag_out  - tag DEPTH cycles after issue (PE output valid)
module pe_tag_pipe
    import pe_sched_pkg::*;
#(
    parameter int DEPTH = PE_LAT
) (
    input  logic clk,
    input  logic rst,
    input  tag_t tag_in,
    output tag_t tag_s1,
    output tag_t tag_out
);
    tag_t [DEPTH-1:0] pipe;

    always_ff @(posedge clk) begin
        if (rst) begin
            pipe <= '0;
        end else begin
            pipe[0] <= tag_in;
            for (int i = 1; i < DEPTH; i++) pipe[i] <= pipe[i-1];
        end
    end

    assign tag_s1  = pipe[0];
    assign tag_out = pipe[DEPTH-1];
endmodule

// File: rtl/pe_conv_sched.sv
// pe_conv_sched: walks every output position and input channel of one conv
// layer, issues 5x5 window requests, and emits PE controls and output buffer
// write strobes aligned with the PE pipeline.
//   clk, rst        - clock, synchronous active-high reset
//   start           - layer start, sampled only in IDLE
//   cfg_in_w        - square input map size (5..32)
//   cfg_in_ch_m1    - input channels - 1
//   cfg_relu/quan/msb - layer options, latched at start
//   busy, done      - layer in progress / 1-cycle end pulse
//   pe              - window request, PE control and write bus (master)
module pe_conv_sched
    import pe_sched_pkg::*;
#(
    parameter int K      = pe_sched_pkg::K,
    parameter int PE_LAT = pe_sched_pkg::PE_LAT
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [5:0]             cfg_in_w,
    input  logic [3:0]             cfg_in_ch_m1,
    input  logic                   cfg_relu,
    input  logic                   cfg_quan,
    input  logic                   cfg_msb,
    output logic                   busy,
    output logic                   done,
    pe_conv_sched_if.master        pe
);
    state_t     state, state_nxt;
    logic [4:0] o_m1, row, col;
    logic [3:0] ch_m1, ch;
    logic       relu_q, quan_q, msb_q;
    logic [1:0] gap_cnt;
    logic [3:0] drain_cnt;
    logic       cfg_ok, hs, last_pos, last_ch, need_gap;
    tag_t       tag_in, tag_s1, tag_s2;

    assign cfg_ok   = cfg_in_w >= 6'(K);
    assign hs       = (state == ISSUE) && pe.win_ready;
    assign last_pos = (row == o_m1) && (col == o_m1);
    assign last_ch  = (ch == ch_m1);
    // With fewer than MIN_GAP positions per channel, the next channel's first
    // psum read would reach the buffer before the previous write lands.
    assign need_gap = pos_cnt(o_m1) < 10'(MIN_GAP);

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = cfg_ok ? ISSUE : DONE;
            ISSUE:   if (hs && last_pos)
                         state_nxt = last_ch ? DRAIN : (need_gap ? GAP : ISSUE);
            GAP:     if (gap_cnt == 2'd0) state_nxt = ISSUE;
            DRAIN:   if (drain_cnt == 4'd0) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            o_m1 <= '0; ch_m1 <= '0; row <= '0; col <= '0; ch <= '0;
            relu_q <= 1'b0; quan_q <= 1'b0; msb_q <= 1'b0;
            gap_cnt <= '0; drain_cnt <= '0;
        end else begin
            if (state == IDLE && start) begin
                relu_q <= cfg_relu;
                quan_q <= cfg_quan;
                msb_q  <= cfg_msb;
                o_m1   <= 5'(cfg_in_w - 6'(K));
                ch_m1  <= cfg_in_ch_m1;
                row    <= '0;
                col    <= '0;
                ch     <= '0;
            end
            // col innermost, then row, then channel
            if (hs) begin
                if (col != o_m1) begin
                    col <= col + 5'd1;
                end else begin
                    col <= '0;
                    if (row != o_m1) begin
                        row <= row + 5'd1;
                    end else begin
                        row <= '0;
                        ch  <= ch + 4'd1;
                    end
                end
            end
            // gap_cnt holds the remaining GAP cycles minus one
            if (hs && last_pos && !last_ch && need_gap)
                gap_cnt <= 2'(10'(MIN_GAP - 1) - pos_cnt(o_m1));
            else if (state == GAP && gap_cnt != 2'd0)
                gap_cnt <= gap_cnt - 2'd1;
            if (hs && last_pos && last_ch)
                drain_cnt <= 4'(PE_LAT - 1);
            else if (state == DRAIN && drain_cnt != 4'd0)
                drain_cnt <= drain_cnt - 4'd1;
        end
    end

    // Stalled cycles push an all-zero tag so they never produce a write.
    always_comb begin
        tag_in = '0;
        if (hs) begin
            tag_in.valid = 1'b1;
            tag_in.row   = row;
            tag_in.col   = col;
            tag_in.last  = last_ch;
            tag_in.nz_ch = (ch != 4'd0);
        end
    end

    pe_tag_pipe #(.DEPTH(PE_LAT)) u_tag_pipe (
        .clk     (clk),
        .rst     (rst),
        .tag_in  (tag_in),
        .tag_s1  (tag_s1),
        .tag_out (tag_s2)
    );

    assign busy         = (state != IDLE);
    assign done         = (state == DONE);
    assign pe.win_valid = (state == ISSUE);
    assign pe.win_row   = pe.win_valid ? row : '0;
    assign pe.win_col   = pe.win_valid ? col : '0;
    assign pe.win_ch    = pe.win_valid ? ch  : '0;
    assign pe.msb_ctrl  = busy & msb_q;
    assign pe.psum_sel  = tag_s1.valid & tag_s1.nz_ch;
    assign pe.wr_valid  = tag_s2.valid;
    assign pe.wr_row    = tag_s2.row;
    assign pe.wr_col    = tag_s2.col;
    assign pe.wr_last   = tag_s2.valid & tag_s2.last;
    assign pe.relu_en   = tag_s2.valid & tag_s2.last & relu_q;
    assign pe.quan_en   = tag_s2.valid & tag_s2.last & quan_q;
endmodule
